instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> ISSUE loop with a single outstanding
// instruction-memory read, a registered issue slot held until the consumer
// accepts it, jump / jump-and-link redirection and a one-cycle link strobe.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [15:0] pc_out,
  input  logic        jump,
  input  logic        jal,
  output logic        link_valid,
  output logic [15:0] link_addr
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [15:0] imem_addr_q, imem_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        link_valid_q, link_valid_d;
  logic [15:0] link_addr_q, link_addr_d;

  logic [15:0] seq_pc;
  logic [15:0] next_pc;
  logic        handshake;

  // Sequential successor of the issued instruction; 16-bit add wraps naturally.
  assign seq_pc    = pc_out_q + 16'd1;
  assign handshake = inst_valid_q && inst_ready;

  // Next-state and registered-output logic; every output is computed here one
  // cycle ahead so the port values come straight from flops.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    inst_valid_d = inst_valid_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    link_valid_d = 1'b0;
    link_addr_d  = link_addr_q;
    next_pc      = seq_pc;

    case (state_q)
      // Single post-reset cycle: present the first request as FETCH begins.
      IDLE: begin
        state_d     = FETCH;
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
      end
      // Request and address stay put until memory answers.
      FETCH: begin
        if (imem_ack) begin
          instr_d      = imem_rdata;
          pc_out_d     = pc_q;
          imem_req_d   = 1'b0;
          inst_valid_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      // Hold the issued instruction; jump/jal only matter at the handshake.
      ISSUE: begin
        if (handshake) begin
          if (jump || jal) next_pc = {pc_out_q[15:12], instr_q[11:0]};
          pc_d         = next_pc;
          imem_req_d   = 1'b1;
          imem_addr_d  = next_pc;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
          if (jal) begin
            link_valid_d = 1'b1;
            link_addr_d  = seq_pc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset abandons any outstanding work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      inst_valid_q <= 1'b0;
      instr_q      <= 16'h0000;
      pc_out_q     <= RESET_PC;
      link_valid_q <= 1'b0;
      link_addr_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_valid_q <= inst_valid_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign instr      = instr_q;
  assign opcode     = instr_q[15:12];
  assign pc_out     = pc_out_q;
  assign link_valid = link_valid_q;
  assign link_addr  = link_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver pushes hand-computed
// expectations, a negedge monitor pops them as the DUT presents requests,
// issued instructions and link strobes.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [15:0] pc_out;
  logic        jump = 1'b0;
  logic        jal = 1'b0;
  logic        link_valid;
  logic [15:0] link_addr;

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instr(instr), .opcode(opcode), .pc_out(pc_out),
    .jump(jump), .jal(jal),
    .link_valid(link_valid), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pc;
  } iss_t;

  logic [15:0] exp_fetch_q[$];
  iss_t        exp_iss_q[$];
  logic [15:0] exp_link_q[$];

  int          checks = 0;
  int          failures = 0;
  logic [15:0] cur_pc = 16'h0000;
  logic        prev_req = 1'b0;
  logic        prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic timeout(input string name);
    flag(name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Monitor: compare each new request, each newly issued instruction and each link strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req && !prev_req) begin
          if (exp_fetch_q.size() == 0) flag("fetch_unexpected");
          else chk("fetch_addr", imem_addr, exp_fetch_q.pop_front());
        end
        if (inst_valid && !prev_vld) begin
          if (exp_iss_q.size() == 0) flag("issue_unexpected");
          else begin
            iss_t e;
            e = exp_iss_q.pop_front();
            chk("issue_instr", instr, e.ins);
            chk("issue_pc", pc_out, e.pc);
            chk("issue_opcode", opcode, e.ins[15:12]);
          end
        end
        if (link_valid) begin
          if (exp_link_q.size() == 0) flag("link_unexpected");
          else chk("link_addr", link_addr, exp_link_q.pop_front());
        end
      end
      prev_req = imem_req;
      prev_vld = inst_valid;
    end
  end

  // Wait for the request, optionally stall the ack (jump/jal toggled as noise), then ack.
  task automatic fetch_ack(input logic [15:0] ins, input int adly);
    int n = 0;
    while (!imem_req) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) timeout("fetch_req_timeout");
    end
    for (int k = 0; k < adly; k++) begin
      jump = 1'b1; jal = 1'b1;
      @(posedge clk); #1;
      chk("fetch_hold_req", imem_req, 1'b1);
      chk("fetch_hold_addr", imem_addr, cur_pc);
    end
    jump = 1'b0; jal = 1'b0;
    imem_ack = 1'b1; imem_rdata = ins;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
  endtask

  task automatic issue(input logic [15:0] ins, input int dly, input bit j, input bit jl);
    int n = 0;
    while (!inst_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) timeout("issue_valid_timeout");
    end
    for (int k = 0; k < dly; k++) begin
      @(posedge clk); #1;
      chk("stall_instr", instr, ins);
      chk("stall_pc", pc_out, cur_pc);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_valid", inst_valid, 1'b1);
    end
    inst_ready = 1'b1; jump = j; jal = jl;
    @(posedge clk); #1;
    inst_ready = 1'b0; jump = 1'b0; jal = 1'b0;
    chk("post_hs_valid", inst_valid, 1'b0);
    chk("post_hs_req", imem_req, 1'b1);
  endtask

  // One instruction: fetch at cur_pc, issue, then expect the next fetch at nxt.
  task automatic go(input logic [15:0] ins, input bit j, input bit jl,
                    input int adly, input int dly,
                    input logic [15:0] nxt, input logic [15:0] lnk);
    exp_iss_q.push_back('{ins: ins, pc: cur_pc});
    fetch_ack(ins, adly);
    exp_fetch_q.push_back(nxt);
    if (jl) exp_link_q.push_back(lnk);
    issue(ins, dly, j, jl);
    cur_pc = nxt;
  endtask

  initial begin
    logic [15:0] a;
    logic [3:0]  nb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_opcode", opcode, 4'h0);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_link", {link_valid, link_addr}, 17'h0);
    exp_fetch_q.push_back(16'h0000);
    rst = 1'b0;

    go(16'h1123, 0, 0, 0, 0, 16'h0001, 16'h0);   // first instruction, then sequential
    go(16'h2000, 0, 0, 2, 3, 16'h0002, 16'h0);   // ack stall 2, ready stall 3
    go(16'hCFFF, 1, 0, 0, 0, 16'h0FFF, 16'h0);
    go(16'h3000, 0, 0, 0, 0, 16'h1000, 16'h0);
    go(16'hCFFF, 1, 0, 0, 0, 16'h1FFF, 16'h0);
    go(16'h3000, 0, 0, 0, 0, 16'h2000, 16'h0);
    go(16'hCFFF, 1, 0, 0, 0, 16'h2FFF, 16'h0);
    go(16'h3000, 0, 0, 0, 0, 16'h3000, 16'h0);
    go(16'hD005, 1, 0, 0, 0, 16'h3005, 16'h0);
    go(16'hA123, 1, 0, 0, 1, 16'h3123, 16'h0);   // jump keeps page, no link
    for (int n = 3; n < 15; n++) begin
      nb = n[3:0];
      a  = {nb, 12'hFFF};
      go(16'hCFFF, 1, 0, 0, 0, a, 16'h0);
      go(16'h0000, 0, 0, 0, 0, a + 16'd1, 16'h0);
    end
    go(16'hCFFF, 1, 0, 0, 0, 16'hFFFF, 16'h0);
    go(16'h4444, 0, 0, 0, 0, 16'h0000, 16'h0);   // wrap FFFF -> 0000
    go(16'h8010, 1, 0, 0, 0, 16'h0010, 16'h0);
    go(16'h7040, 0, 1, 0, 0, 16'h0040, 16'h0011); // jal
    go(16'h9050, 1, 1, 0, 0, 16'h0050, 16'h0041); // jump+jal acts as jal

    // Reset while FETCH at 0050 awaits ack; a late ack must be dropped.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_valid", inst_valid, 1'b0);
    chk("mid_rst_instr", instr, 16'h0000);
    chk("mid_rst_pc_out", pc_out, 16'h0000);
    exp_fetch_q.push_back(16'h0000);
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    chk("late_ack_valid", inst_valid, 1'b0);
    chk("late_ack_req", imem_req, 1'b1);
    chk("late_ack_addr", imem_addr, 16'h0000);
    cur_pc = 16'h0000;
    go(16'h5555, 0, 0, 1, 0, 16'h0001, 16'h0);

    repeat (4) @(posedge clk);
    #1;
    chk("left_fetch", exp_fetch_q.size(), 0);
    chk("left_issue", exp_iss_q.size(), 0);
    chk("left_link", exp_link_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
